// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types used by the CDB arbiter.
// Holds the branch tag type, the CDB broadcast packet and the pointer helper.
package rv32i_types;

  localparam int unsigned BR_TAG_WIDTH  = 4;
  localparam int unsigned ROB_WIDTH_MAX = 64;

  typedef logic [BR_TAG_WIDTH-1:0] branch_tag_t;

  // One CDB broadcast. The rob field is sized for the widest ROB tag; narrower
  // configurations use its low bits and keep the rest at zero.
  typedef struct packed {
    logic [31:0]              data;
    logic [31:0]              pc_addr;
    logic                     br_taken;
    logic                     is_br;
    branch_tag_t              br_tag;
    logic [ROB_WIDTH_MAX-1:0] rob;
  } cdb_pkt_t;

  // Advance an index by one, wrapping from n-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker: circular first-request search starting at start_ptr.
// Produces a one-hot grant, the binary index of the winner and an any-request
// flag. Tying start_ptr to zero turns it into a fixed lowest-index picker.
module rr_picker #(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   start_ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [31:0] cand;

  // Walk the requests from start_ptr, wrapping; the first set request wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = 32'(start_ptr) + k;
      if (cand >= NUM_SRC) begin
        cand = cand - NUM_SRC;
      end
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                      = 1'b1;
        grant[cand[IDX_W-1:0]]   = 1'b1;
        idx                      = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: Common Data Bus arbiter/broadcaster.
// Picks one pending FU result per cycle, returns a combinational one-hot
// taken pulse to the winner and broadcasts its payload one cycle later.
// Build option: define CDB_RR_EN for round-robin arbitration; otherwise the
// lowest-index valid source always wins.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter  int unsigned NUM_SRC   = 4,
  parameter  int unsigned ROB_WIDTH = 64,
  localparam int unsigned IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [31:0]          src_data     [NUM_SRC],
  input  logic [31:0]          src_pc_addr  [NUM_SRC],
  input  logic [NUM_SRC-1:0]   src_br_taken,
  input  logic [NUM_SRC-1:0]   src_is_br,
  input  branch_tag_t          src_br_tag   [NUM_SRC],
  input  logic [ROB_WIDTH-1:0] src_rob      [NUM_SRC],
  output logic [NUM_SRC-1:0]   src_taken,
  output logic                 cdb_valid,
  output logic [31:0]          cdb_data,
  output logic [31:0]          cdb_pc_addr,
  output logic                 cdb_br_taken,
  output logic                 cdb_is_br,
  output branch_tag_t          cdb_br_tag,
  output logic [ROB_WIDTH-1:0] cdb_rob,
  output logic [IDX_W-1:0]     cdb_src
);

  logic [NUM_SRC-1:0] grant;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   start_ptr;
  logic               pick_any;
  logic               kill;
  cdb_pkt_t           pick_pkt;
  cdb_pkt_t           pkt_q;
  logic               valid_q;
  logic [IDX_W-1:0]   src_q;

  assign kill = rst | flush;

`ifdef CDB_RR_EN
  logic [IDX_W-1:0] rr_ptr;

  // Priority pointer: moves just past the winner on each grant, held when idle.
  always_ff @(posedge clk) begin
    if (kill) begin
      rr_ptr <= '0;
    end else if (pick_any) begin
      rr_ptr <= IDX_W'(wrap_inc(32'(pick_idx), NUM_SRC));
    end
  end

  assign start_ptr = rr_ptr;
`else
  assign start_ptr = '0;
`endif

  rr_picker #(
    .NUM_SRC (NUM_SRC)
  ) u_picker (
    .req       (src_valid),
    .start_ptr (start_ptr),
    .grant     (grant),
    .idx       (pick_idx),
    .any       (pick_any)
  );

  // A cycle that is being reset or flushed must not consume any FU result.
  assign src_taken = kill ? '0 : grant;

  // Payload mux: gather the winner's fields into one broadcast packet.
  always_comb begin
    pick_pkt                       = '0;
    pick_pkt.data                  = src_data[pick_idx];
    pick_pkt.pc_addr               = src_pc_addr[pick_idx];
    pick_pkt.br_taken              = src_br_taken[pick_idx];
    pick_pkt.is_br                 = src_is_br[pick_idx];
    pick_pkt.br_tag                = src_br_tag[pick_idx];
    pick_pkt.rob[ROB_WIDTH-1:0]    = src_rob[pick_idx];
  end

  // Broadcast register: winner captured at the edge, zeros when idle or killed.
  always_ff @(posedge clk) begin
    if (kill || !pick_any) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
      src_q   <= '0;
    end else begin
      valid_q <= 1'b1;
      pkt_q   <= pick_pkt;
      src_q   <= pick_idx;
    end
  end

  assign cdb_valid    = valid_q;
  assign cdb_data     = pkt_q.data;
  assign cdb_pc_addr  = pkt_q.pc_addr;
  assign cdb_br_taken = pkt_q.br_taken;
  assign cdb_is_br    = pkt_q.is_br;
  assign cdb_br_tag   = pkt_q.br_tag;
  assign cdb_rob      = pkt_q.rob[ROB_WIDTH-1:0];
  assign cdb_src      = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by random
// FU traffic, all compared against a distance-based arbitration model.
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int N = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [N-1:0]      src_valid;
  logic [31:0]       src_data    [N];
  logic [31:0]       src_pc_addr [N];
  logic [N-1:0]      src_br_taken;
  logic [N-1:0]      src_is_br;
  branch_tag_t       src_br_tag  [N];
  logic [63:0]       src_rob     [N];
  logic [N-1:0]      src_taken;
  logic              cdb_valid;
  logic [31:0]       cdb_data;
  logic [31:0]       cdb_pc_addr;
  logic              cdb_br_taken;
  logic              cdb_is_br;
  branch_tag_t       cdb_br_tag;
  logic [63:0]       cdb_rob;
  logic [1:0]        cdb_src;

  cdb_arbiter #(
    .NUM_SRC   (N),
    .ROB_WIDTH (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_pc_addr  (src_pc_addr),
    .src_br_taken (src_br_taken),
    .src_is_br    (src_is_br),
    .src_br_tag   (src_br_tag),
    .src_rob      (src_rob),
    .src_taken    (src_taken),
    .cdb_valid    (cdb_valid),
    .cdb_data     (cdb_data),
    .cdb_pc_addr  (cdb_pc_addr),
    .cdb_br_taken (cdb_br_taken),
    .cdb_is_br    (cdb_is_br),
    .cdb_br_tag   (cdb_br_tag),
    .cdb_rob      (cdb_rob),
    .cdb_src      (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model state: next-cycle expected broadcast and priority start.
  int          mptr;
  int          last_w;
  logic        last_kill;
  logic        exp_valid;
  logic [31:0] exp_data;
  logic [31:0] exp_pc;
  logic        exp_brt;
  logic        exp_isbr;
  logic [3:0]  exp_tag;
  logic [63:0] exp_rob;
  int          exp_src;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  // Winner = valid source at the smallest circular distance from the start pointer.
  function automatic int model_winner(input logic [N-1:0] v, input int ptr);
    int best  = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int d = (i - ptr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic clear_exp();
    exp_valid = 1'b0; exp_data = '0; exp_pc = '0; exp_brt = 1'b0;
    exp_isbr = 1'b0; exp_tag = '0; exp_rob = '0; exp_src = 0;
  endtask

  // One clock: check grant and registered outputs, then advance the model.
  task automatic cycle();
    int w;
    #1;
    w = (rst || flush) ? -1 : model_winner(src_valid, mptr);
    chk("src_taken", src_taken, (w < 0) ? 64'd0 : (64'd1 << w));
    chk("cdb_valid", cdb_valid, exp_valid);
    chk("cdb_data", cdb_data, exp_data);
    chk("cdb_pc_addr", cdb_pc_addr, exp_pc);
    chk("cdb_br_taken", cdb_br_taken, exp_brt);
    chk("cdb_is_br", cdb_is_br, exp_isbr);
    chk("cdb_br_tag", cdb_br_tag, exp_tag);
    chk("cdb_rob", cdb_rob, exp_rob);
    chk("cdb_src", cdb_src, 64'(exp_src));
    @(posedge clk);
    last_w    = w;
    last_kill = rst || flush;
    if (rst || flush) begin
      clear_exp();
      mptr = 0;
    end else if (w >= 0) begin
      exp_valid = 1'b1;
      exp_data  = src_data[w];
      exp_pc    = src_pc_addr[w];
      exp_brt   = src_br_taken[w];
      exp_isbr  = src_is_br[w];
      exp_tag   = src_br_tag[w];
      exp_rob   = src_rob[w];
      exp_src   = w;
`ifdef CDB_RR_EN
      mptr = (w + 1) % N;
`endif
    end else begin
      clear_exp();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] pending;
    logic [N-1:0] exp_g;

    rst = 1'b1; flush = 1'b0; src_valid = '0; src_br_taken = '0; src_is_br = '0;
    for (int i = 0; i < N; i++) begin
      src_data[i] = '0; src_pc_addr[i] = '0; src_br_tag[i] = '0; src_rob[i] = '0;
    end
    mptr = 0; last_w = -1; last_kill = 1'b0;
    clear_exp();
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset state: everything zero while rst is held.
    do_reset();

    // 1: lone src2 request, broadcast one cycle later.
    src_valid = 4'b0100; src_data[2] = 32'h1234; src_rob[2] = 64'd5;
    #1 chk("t1_taken", src_taken, 4'b0100);
    cycle();
    src_valid = '0;
    #1;
    chk("t1_valid", cdb_valid, 1'b1);
    chk("t1_data", cdb_data, 32'h1234);
    chk("t1_rob", cdb_rob, 64'd5);
    cycle();

    // 2: src0 and src2 from pointer 0.
    do_reset();
    src_valid = 4'b0101;
    #1 chk("t2_first", src_taken, 4'b0001);
    cycle();
    src_valid = 4'b0100;
    #1;
    chk("t2_src0", cdb_src, 2'd0);
    chk("t2_second", src_taken, 4'b0100);
    cycle();
    src_valid = '0;
    #1 chk("t2_src2", cdb_src, 2'd2);
    cycle();

    // 3: all four held valid for 8 cycles.
    do_reset();
    src_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
`ifdef CDB_RR_EN
      exp_g = 4'b0001 << (k % 4);
`else
      exp_g = 4'b0001;
`endif
      #1 chk("t3_grant", src_taken, exp_g);
      cycle();
    end
    src_valid = '0;
    cycle();

    // 4: branch resolution from the CMP unit on src2.
    src_valid = 4'b0100; src_is_br[2] = 1'b1; src_br_taken[2] = 1'b1;
    src_pc_addr[2] = 32'h6000_0040; src_br_tag[2] = 4'h9;
    cycle();
    src_valid = '0;
    #1;
    chk("t4_is_br", cdb_is_br, 1'b1);
    chk("t4_br_taken", cdb_br_taken, 1'b1);
    chk("t4_pc", cdb_pc_addr, 32'h6000_0040);
    cycle();

    // 5: flush one cycle after a grant kills the broadcast.
    src_valid = 4'b0010;
    cycle();
    flush = 1'b1; src_valid = 4'b1000;
    #1 chk("t5_flush_taken", src_taken, 4'b0000);
    cycle();
    flush = 1'b0; src_valid = '0;
    #1 chk("t5_killed", cdb_valid, 1'b0);
    cycle();

    // 6: reset in the middle of traffic.
    src_valid = 4'b1111;
    cycle();
    cycle();
    rst = 1'b1;
    #1 chk("t6_rst_taken", src_taken, 4'b0000);
    cycle();
    rst = 1'b0;
    #1;
    chk("t6_valid", cdb_valid, 1'b0);
    chk("t6_data", cdb_data, 32'h0);
    chk("t6_src", cdb_src, 2'd0);
    chk("t6_first", src_taken, 4'b0001);
    cycle();

    // 7: idle cycles leave the pointer where the last grant put it.
    src_valid = 4'b0010;
    cycle();
    src_valid = '0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t7_idle_taken", src_taken, 4'b0000);
      cycle();
    end
    #1 chk("t7_idle_valid", cdb_valid, 1'b0);
    src_valid = 4'b1111;
`ifdef CDB_RR_EN
    exp_g = 4'b0100;
`else
    exp_g = 4'b0001;
`endif
    #1 chk("t7_resume", src_taken, exp_g);
    cycle();

    // Random FU traffic: results held until taken, cleared on flush or reset.
    src_valid = '0;
    do_reset();
    pending = '0;
    for (int n = 0; n < 400; n++) begin
      if (last_kill) pending = '0;
      else if (last_w >= 0) pending[last_w] = 1'b0;
      rst   = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 5);
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 99) < 40) begin
          pending[i]      = 1'b1;
          src_data[i]     = $urandom;
          src_pc_addr[i]  = $urandom;
          src_is_br[i]    = 1'($urandom);
          src_br_taken[i] = 1'($urandom);
          src_br_tag[i]   = 4'($urandom);
          src_rob[i]      = {$urandom, $urandom};
        end
      end
      src_valid = pending;
      cycle();
    end
    rst = 1'b0; flush = 1'b0; src_valid = '0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
